// File: rtl/led_bar_pkg.sv
// Shared constants and state encoding for the LED bar arbiter.
package led_bar_pkg;
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OPEN = 2'd2
  } state_t;
endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin search: first set request after last_owner, wrapping.
module led_rr_pick
  import led_bar_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  always_comb begin
    int unsigned idx;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_owner) + k) % N_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/led_bar_arbiter.sv
// Round-robin arbiter granting one requester at a time the LED bar, with a
// minimum tenure before the grant may be handed to another requester.
module led_bar_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned HOLD_CYCLES  = 3_200_000,
  parameter logic [7:0]  IDLE_PATTERN = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*8-1:0] pat,
  output logic [N_REQ-1:0]   gnt,
  output logic [1:0]         owner,
  output logic               busy,
  output logic [7:0]         led
);
  import led_bar_pkg::*;

  localparam int unsigned    CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_last_owner, w_last_nxt;
  logic [LANE_W-1:0]  r_led, w_led_nxt;

  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_winner;
  logic [N_REQ-1:0]   w_pick_req;
  logic               w_owner_req;
  logic               w_done;

  // Excluding the current owner lets one search serve both IDLE and handover.
  assign w_pick_req  = req & ~r_gnt;
  assign w_owner_req = req[r_owner];
  assign w_done      = (r_cnt == CNT_LAST);

  led_rr_pick u_pick (
    .req        (w_pick_req),
    .last_owner (r_last_owner),
    .valid      (w_pick_valid),
    .winner     (w_pick_winner)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_led_nxt   = (r_gnt == '0) ? IDLE_PATTERN : pat[LANE_W*r_owner +: LANE_W];

    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_gnt_nxt   = N_REQ'(1) << w_pick_winner;
          w_owner_nxt = w_pick_winner;
          w_last_nxt  = w_pick_winner;
        end
      end
      HOLD, OPEN: begin
        if (!w_owner_req) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
        // The last HOLD cycle already counts as tenure satisfied, so a
        // waiting requester takes over after exactly HOLD_CYCLES cycles.
        end else if (r_state == OPEN || w_done) begin
          if (w_pick_valid) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = '0;
            w_gnt_nxt   = N_REQ'(1) << w_pick_winner;
            w_owner_nxt = w_pick_winner;
            w_last_nxt  = w_pick_winner;
          end else begin
            w_state_nxt = OPEN;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(N_REQ - 1);
      r_led        <= IDLE_PATTERN;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gnt        <= w_gnt_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_led        <= w_led_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = (r_state != IDLE);
  assign led   = r_led;

endmodule

// File: tb/tb_led_bar_arbiter.sv
// Directed self-checking bench for led_bar_arbiter with a 4-cycle tenure.
module tb_led_bar_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] pat;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  led;

  int n_total = 0;
  int n_bad   = 0;

  led_bar_arbiter #(
    .N_REQ        (4),
    .HOLD_CYCLES  (4),
    .IDLE_PATTERN (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .pat   (pat),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .led   (led)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    pat   = 32'hFFFF_FFFF;
    step();
    step();
    n_total++;
    if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    n_total++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_total++;
    if (owner !== 2'd0) begin n_bad++; $display("FAIL reset_owner got=%0d want=0", owner); end
    n_total++;
    if (led !== 8'h00) begin n_bad++; $display("FAIL reset_led got=%h want=00", led); end
    reset = 1'b0;
    req   = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step();
      n_total++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || led !== 8'h00) begin
        n_bad++;
        $display("FAIL idle_quiet cyc=%0d got gnt=%b busy=%b led=%h want 0000/0/00", i, gnt, busy, led);
      end
    end
  endtask

  task automatic test_two_req();
    pat = 32'h0018_0081;
    req = 4'b0101;
    step();
    n_total++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || owner !== 2'd0) begin
      n_bad++; $display("FAIL first_grant got gnt=%b busy=%b owner=%0d want 0001/1/0", gnt, busy, owner);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_total++;
      if (gnt !== 4'b0001) begin n_bad++; $display("FAIL tenure0 edge=%0d got=%b want=0001", i, gnt); end
      if (i == 1) begin
        n_total++;
        if (led !== 8'h81) begin n_bad++; $display("FAIL led_lane0 got=%h want=81", led); end
      end
    end
    step();
    n_total++;
    if (gnt !== 4'b0100 || owner !== 2'd2) begin
      n_bad++; $display("FAIL handover got gnt=%b owner=%0d want 0100/2", gnt, owner);
    end
    n_total++;
    if (led !== 8'h81) begin n_bad++; $display("FAIL led_before_switch got=%h want=81", led); end
    step();
    n_total++;
    if (led !== 8'h18) begin n_bad++; $display("FAIL led_lane2 got=%h want=18", led); end
    req = 4'b0000;
    step();
    n_total++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL drop_idle got gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    step();
    n_total++;
    if (led !== 8'h00) begin n_bad++; $display("FAIL led_idle got=%h want=00", led); end
  endtask

  task automatic test_hold_open();
    pat = 32'hA5A5_3CA5;
    req = 4'b0010;
    step();
    n_total++;
    if (gnt !== 4'b0010 || owner !== 2'd1) begin
      n_bad++; $display("FAIL open_grant got gnt=%b owner=%0d want 0010/1", gnt, owner);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_total++;
      if (gnt !== 4'b0010 || led !== 8'h3C) begin
        n_bad++; $display("FAIL open_keep cyc=%0d got gnt=%b led=%h want 0010/3c", i, gnt, led);
      end
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_drop();
    pat = 32'h0000_0000;
    req = 4'b0001;
    step();
    n_total++;
    if (gnt !== 4'b0001) begin n_bad++; $display("FAIL drop_grant0 got=%b want=0001", gnt); end
    req = 4'b1001;
    step();
    n_total++;
    if (gnt !== 4'b0001) begin n_bad++; $display("FAIL no_preempt got=%b want=0001", gnt); end
    req = 4'b1000;
    step();
    n_total++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL gap_cycle got gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    step();
    n_total++;
    if (gnt !== 4'b1000 || owner !== 2'd3) begin
      n_bad++; $display("FAIL regrant3 got gnt=%b owner=%0d want 1000/3", gnt, owner);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] shifted;
    int          exp_o;
    int          prev_o;
    pat = 32'h4433_2211;
    req = 4'b1111;
    prev_o = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      exp_o = (k / 4) % 4;
      n_total++;
      if (gnt !== (4'b0001 << exp_o) || owner !== 2'(exp_o) || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL rotate k=%0d got gnt=%b owner=%0d busy=%b want owner=%0d", k, gnt, owner, busy, exp_o);
      end
      if (prev_o >= 0) begin
        shifted = pat >> (8 * prev_o);
        n_total++;
        if (led !== shifted[7:0]) begin
          n_bad++; $display("FAIL rotate_led k=%0d got=%h want=%h", k, led, shifted[7:0]);
        end
      end
      prev_o = exp_o;
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    pat = 32'h0077_6600;
    req = 4'b0100;
    step();
    n_total++;
    if (gnt !== 4'b0100) begin n_bad++; $display("FAIL mid_grant2 got=%b want=0100", gnt); end
    req = 4'b0110;
    step();
    n_total++;
    if (gnt !== 4'b0100 || led !== 8'h77) begin
      n_bad++; $display("FAIL mid_hold got gnt=%b led=%h want 0100/77", gnt, led);
    end
    reset = 1'b1;
    step();
    n_total++;
    if (gnt !== 4'b0000 || led !== 8'h00 || busy !== 1'b0 || owner !== 2'd0) begin
      n_bad++; $display("FAIL mid_reset got gnt=%b led=%h busy=%b owner=%0d want 0000/00/0/0", gnt, led, busy, owner);
    end
    reset = 1'b0;
    step();
    n_total++;
    if (gnt !== 4'b0010 || owner !== 2'd1) begin
      n_bad++; $display("FAIL post_reset got gnt=%b owner=%0d want 0010/1", gnt, owner);
    end
    step();
    n_total++;
    if (led !== 8'h66) begin n_bad++; $display("FAIL post_reset_led got=%h want=66", led); end
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    pat   = '0;
    test_reset();
    test_two_req();
    test_hold_open();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
